// File: rtl/mix_columns_pipe.sv
// Two-stage valid/ready AES column stage: AddRoundKey plus MixColumns/InvMixColumns
// over LANES 32-bit columns per beat, with beat-count and round-range protocol checking.
module mix_columns_pipe #(
  parameter int LANES = 1,
  parameter int NR    = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*LANES-1:0]  in_col,
  input  logic [32*LANES-1:0]  in_key,
  input  logic [3:0]           in_rnd,
  input  logic                 in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*LANES-1:0]  out_col,
  output logic [3:0]           out_rnd,
  output logic                 out_last,
  output logic                 err
);

  localparam int BEATS = 4 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [3:0]    NR_L     = 4'(NR);

  // Handshake: a beat moves across a boundary only in a cycle where valid and
  // ready are both high; a stage refills when it is empty or draining this cycle.
  logic a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [32*LANES-1:0] a_col_q, a_col_d, a_key_q, a_key_d;
  logic [3:0]          a_rnd_q, a_rnd_d;
  logic                a_mode_q, a_mode_d, a_last_q, a_last_d;
  logic [32*LANES-1:0] b_col_q, b_col_d;
  logic [3:0]          b_rnd_q, b_rnd_d;
  logic                b_last_q, b_last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                a_adv, b_adv, in_fire, bypass, is_last_cnt;
  logic [32*LANES-1:0] mix_res;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Inverse coefficients built from x2/x4/x8 multiples: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign b_adv    = !b_valid_q || out_ready;
  assign a_adv    = !a_valid_q || b_adv;
  assign in_ready = a_adv && reset_n;
  assign in_fire  = in_valid && in_ready;
  assign is_last_cnt = (cnt_q == LAST_CNT);

  always_comb begin
    bypass  = (a_rnd_q == 4'd0) || (a_rnd_q >= NR_L);
    mix_res = '0;
    for (int k = 0; k < LANES; k++) begin
      if (bypass)
        mix_res[32*k +: 32] = a_col_q[32*k +: 32] ^ a_key_q[32*k +: 32];
      else if (a_mode_q)
        mix_res[32*k +: 32] = mix_inv(a_col_q[32*k +: 32] ^ a_key_q[32*k +: 32]);
      else
        mix_res[32*k +: 32] = mix_fwd(a_col_q[32*k +: 32]) ^ a_key_q[32*k +: 32];
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_col_d   = a_col_q;
    a_key_d   = a_key_q;
    a_rnd_d   = a_rnd_q;
    a_mode_d  = a_mode_q;
    a_last_d  = a_last_q;
    b_valid_d = b_valid_q;
    b_col_d   = b_col_q;
    b_rnd_d   = b_rnd_q;
    b_last_d  = b_last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (a_adv) begin
      a_valid_d = in_fire;
      if (in_fire) begin
        a_col_d  = in_col;
        a_key_d  = in_key;
        a_rnd_d  = in_rnd;
        a_mode_d = in_mode;
        a_last_d = in_last;
      end
    end
    if (b_adv) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_col_d  = mix_res;
        b_rnd_d  = a_rnd_q;
        b_last_d = a_last_q;
      end
    end
    // An early in_last resynchronises the block count rather than carrying the slip forward.
    if (in_fire) begin
      if ((in_last != is_last_cnt) || (in_rnd > NR_L)) err_d = 1'b1;
      if (in_last || is_last_cnt || (BEATS == 1)) cnt_d = '0;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid_q <= 1'b0;
      a_col_q   <= '0;
      a_key_q   <= '0;
      a_rnd_q   <= '0;
      a_mode_q  <= 1'b0;
      a_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_col_q   <= '0;
      b_rnd_q   <= '0;
      b_last_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_col_q   <= a_col_d;
      a_key_q   <= a_key_d;
      a_rnd_q   <= a_rnd_d;
      a_mode_q  <= a_mode_d;
      a_last_q  <= a_last_d;
      b_valid_q <= b_valid_d;
      b_col_q   <= b_col_d;
      b_rnd_q   <= b_rnd_d;
      b_last_q  <= b_last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_col   = b_col_q;
  assign out_rnd   = b_rnd_q;
  assign out_last  = b_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Directed-vector bench for mix_columns_pipe: one-lane and four-lane instances,
// latency, bypass rounds, backpressure ordering, protocol error and mid-stream reset.
module tb_mix_columns_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_mode, in_last;
  logic [31:0] in_col, in_key;
  logic [3:0]  in_rnd;
  logic        out_valid, out_ready, out_last, err;
  logic [31:0] out_col;
  logic [3:0]  out_rnd;

  logic         in_valid4, in_ready4, out_valid4, out_last4, err4;
  logic [127:0] in_col4, in_key4, out_col4;
  logic [3:0]   out_rnd4;

  int n_vec = 0;
  int n_err = 0;
  int tb_cnt = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  mix_columns_pipe #(.LANES(1), .NR(14)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col), .in_key(in_key),
    .in_rnd(in_rnd), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_rnd(out_rnd), .out_last(out_last), .err(err)
  );

  mix_columns_pipe #(.LANES(4), .NR(14)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_col(in_col4), .in_key(in_key4),
    .in_rnd(4'd1), .in_mode(1'b0), .in_last(1'b1),
    .out_valid(out_valid4), .out_ready(1'b1), .out_col(out_col4),
    .out_rnd(out_rnd4), .out_last(out_last4), .err(err4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tb_cnt = 0;
  endtask

  task automatic send_single(input logic [31:0] col, input logic [31:0] key,
                             input logic [3:0] rnd, input logic mode, input logic last,
                             input logic [31:0] exp_col, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1; in_col = col; in_key = key; in_rnd = rnd; in_mode = mode; in_last = last;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_ready: got in_ready=%b, want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tb_cnt = last ? 0 : (tb_cnt + 1) % 4;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s_early: got out_valid=%b one cycle after transfer, want 0", name, out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_col !== exp_col || out_rnd !== rnd || out_last !== last) begin
      n_err++;
      $display("FAIL %s: got valid=%b col=%h rnd=%h last=%b, want valid=1 col=%h rnd=%h last=%b",
               name, out_valid, out_col, out_rnd, out_last, exp_col, rnd, last);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    in_col = '0; in_key = '0; in_rnd = '0; in_mode = 1'b0; in_last = 1'b0;
    in_col4 = '0; in_key4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_col !== 32'h0 || out_rnd !== 4'h0 ||
        out_last !== 1'b0 || err !== 1'b0 || out_valid4 !== 1'b0 || err4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b col=%h rnd=%h last=%b err=%b v4=%b e4=%b, want all 0",
               in_ready, out_valid, out_col, out_rnd, out_last, err, out_valid4, err4);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    tb_cnt = 0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_forward();
    send_single(32'hdb135345, 32'h0, 4'd1, 1'b0, tb_cnt == 3, 32'h8e4da1bc, "fwd_a");
    send_single(32'hf20a225c, 32'h0, 4'd1, 1'b0, tb_cnt == 3, 32'h9fdc589d, "fwd_b");
  endtask

  task automatic test_inverse();
    send_single(32'h8e4da1bc ^ 32'h0f0f0f0f, 32'h0f0f0f0f, 4'd5, 1'b1, tb_cnt == 3,
                32'hdb135345, "inv_key");
  endtask

  task automatic test_bypass();
    send_single(32'h01020304, 32'h10203040, 4'd0, 1'b0, tb_cnt == 3, 32'h11223344, "bypass_r0");
    send_single(32'h01020304, 32'h10203040, 4'd14, 1'b1, tb_cnt == 3, 32'h11223344, "bypass_rnr");
    n_vec++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL bypass_err_clear: got err=%b, want 0", err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bp_col [8];
    logic [31:0] bp_key [8];
    logic [31:0] bp_exp [8];
    logic [3:0]  bp_rnd [8];
    int acc = 0;
    int popped = 0;
    bp_col[0] = 32'hdb135345; bp_key[0] = 32'h0;        bp_rnd[0] = 4'd3; bp_exp[0] = 32'h8e4da1bc;
    bp_col[1] = 32'hf20a225c; bp_key[1] = 32'h0;        bp_rnd[1] = 4'd3; bp_exp[1] = 32'h9fdc589d;
    bp_col[2] = 32'h01010101; bp_key[2] = 32'h0;        bp_rnd[2] = 4'd3; bp_exp[2] = 32'h01010101;
    bp_col[3] = 32'hc6c6c6c6; bp_key[3] = 32'h0;        bp_rnd[3] = 4'd3; bp_exp[3] = 32'hc6c6c6c6;
    bp_col[4] = 32'hd4d4d4d5; bp_key[4] = 32'h0;        bp_rnd[4] = 4'd3; bp_exp[4] = 32'hd5d5d7d6;
    bp_col[5] = 32'h2d26314c; bp_key[5] = 32'h0;        bp_rnd[5] = 4'd3; bp_exp[5] = 32'h4d7ebdf8;
    bp_col[6] = 32'hdb135345; bp_key[6] = 32'h00000001; bp_rnd[6] = 4'd3; bp_exp[6] = 32'h8e4da1bd;
    bp_col[7] = 32'haabbccdd; bp_key[7] = 32'hffffffff; bp_rnd[7] = 4'd0; bp_exp[7] = 32'h55443322;
    exp_q.delete();
    @(posedge clk); #1;
    fork
      begin : driver
        for (int i = 0; i < 8; i++) begin
          int t = 0;
          in_valid = 1'b1; in_col = bp_col[i]; in_key = bp_key[i]; in_rnd = bp_rnd[i];
          in_mode = 1'b0; in_last = (tb_cnt == 3);
          @(negedge clk);
          while (!in_ready && t < 20) begin @(negedge clk); t++; end
          if (t >= 20) begin
            n_vec++; n_err++; $display("FAIL bp_accept_timeout: beat %0d not accepted", i);
          end
          @(posedge clk); #1;
          exp_q.push_back({in_last, bp_exp[i]});
          tb_cnt = in_last ? 0 : (tb_cnt + 1) % 4;
          acc++;
        end
        in_valid = 1'b0;
      end
      begin : stall
        int t = 0;
        while (acc < 3 && t < 100) begin @(posedge clk); #2; t++; end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_vec++;
          if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_in_ready_stall: got in_ready=%b with both stages full, want 0", in_ready);
          end
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
      begin : monitor
        int t = 0;
        logic held_v = 1'b0;
        logic [31:0] held = '0;
        while (popped < 8 && t < 200) begin
          @(negedge clk); t++;
          if (out_valid === 1'b1 && out_ready === 1'b0) begin
            if (held_v) begin
              n_vec++;
              if (out_col !== held) begin
                n_err++; $display("FAIL bp_stall_hold: got col=%h, want %h", out_col, held);
              end
            end
            held_v = 1'b1; held = out_col;
          end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [32:0] e;
            held_v = 1'b0;
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL bp_extra: got col=%h with no beat outstanding, want none", out_col);
            end else begin
              e = exp_q.pop_front();
              if ({out_last, out_col} !== e) begin
                n_err++; $display("FAIL bp_beat%0d: got last=%b col=%h, want last=%b col=%h",
                                  popped, out_last, out_col, e[32], e[31:0]);
              end
            end
            popped++;
          end
        end
        if (popped < 8) begin
          n_vec++; n_err++; $display("FAIL bp_timeout: got %0d outputs, want 8", popped);
        end
      end
    join
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_end: got err=%b pending=%0d, want 0/0", err, exp_q.size());
    end
  endtask

  task automatic test_rnd_err();
    send_single(32'h01020304, 32'h10203040, 4'd15, 1'b0, tb_cnt == 3, 32'h11223344, "rnd15");
    n_vec++;
    if (err !== 1'b1) begin
      n_err++; $display("FAIL rnd15_err: got err=%b, want 1", err);
    end
  endtask

  task automatic test_lanes4();
    @(posedge clk); #1;
    in_valid4 = 1'b1;
    in_col4 = {32'hf20a225c, 32'h0, 32'h0, 32'hdb135345};
    in_key4 = '0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid4 !== 1'b1 || out_col4 !== {32'h9fdc589d, 32'h0, 32'h0, 32'h8e4da1bc} ||
        out_last4 !== 1'b1 || out_rnd4 !== 4'd1 || err4 !== 1'b0) begin
      n_err++;
      $display("FAIL lanes4: got valid=%b col=%h last=%b rnd=%h err=%b, want 1 9fdc589d00000000000000008e4da1bc 1 1 0",
               out_valid4, out_col4, out_last4, out_rnd4, err4);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    send_single(32'h01020304, 32'h10203040, 4'd0, 1'b0, 1'b0, 32'h11223344, "proto_b0");
    send_single(32'h01020304, 32'h10203040, 4'd0, 1'b0, 1'b1, 32'h11223344, "proto_b1");
    n_vec++;
    if (err !== 1'b1 || dut.cnt_q !== 2'd0) begin
      n_err++; $display("FAIL proto_early_last: got err=%b cnt=%0d, want 1/0", err, dut.cnt_q);
    end
    send_single(32'hdb135345, 32'h0, 4'd2, 1'b0, 1'b0, 32'h8e4da1bc, "proto_blk0");
    send_single(32'hf20a225c, 32'h0, 4'd2, 1'b0, 1'b0, 32'h9fdc589d, "proto_blk1");
    send_single(32'h8e4da1bc, 32'h0, 4'd2, 1'b1, 1'b0, 32'hdb135345, "proto_blk2");
    send_single(32'h01020304, 32'h10203040, 4'd14, 1'b0, 1'b1, 32'h11223344, "proto_blk3");
    n_vec++;
    if (dut.cnt_q !== 2'd0) begin
      n_err++; $display("FAIL proto_cnt_wrap: got cnt=%0d, want 0", dut.cnt_q);
    end
  endtask

  task automatic test_midstream_reset();
    logic stale;
    @(posedge clk); #1;
    in_valid = 1'b1; in_col = 32'hdb135345; in_key = '0; in_rnd = 4'd1; in_mode = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    in_col = 32'hf20a225c;
    @(posedge clk); #1;
    in_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_col !== 32'h8e4da1bc) begin
      n_err++; $display("FAIL mid_inflight: got valid=%b col=%h, want 1 8e4da1bc", out_valid, out_col);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tb_cnt = 0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || err !== 1'b0 || out_col !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: got valid=%b err=%b col=%h, want 0 0 0", out_valid, err, out_col);
    end
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_vec++;
    if (stale) begin
      n_err++; $display("FAIL mid_stale: got out_valid=1 after reset, want 0");
    end
    send_single(32'hf20a225c, 32'h0, 4'd1, 1'b0, tb_cnt == 3, 32'h9fdc589d, "mid_after");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_bypass();
    test_back_to_back();
    test_lanes4();
    test_rnd_err();
    test_protocol();
    test_midstream_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
